sram_controller: RTL

SRAM_CONTROLLER -- requirements
Module: sram_controller

---
 rtl/sram_controller.sv | 128 ++++++++++++
 1 files changed

// File: rtl/sram_controller.sv
// Memory-stage bridge from a 32-bit load/store port to an external 16-bit asynchronous SRAM.
// Each word is moved as two halfword beats (low, then high), each held for WAIT_STATES+1 cycles.
module sram_controller #(
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned BASE_ADDR   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] SRAM_ADDR,
  inout  wire  [15:0] SRAM_DQ,
  output logic        SRAM_WE_N
);

  localparam logic [2:0]  WS   = 3'(WAIT_STATES);
  localparam logic [31:0] BASE = 32'(BASE_ADDR);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOW  = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [16:0] word_q, word_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;

  logic        req;
  logic        in_beat;
  logic        last_beat;
  logic        dq_drive;
  logic [15:0] dq_out;
  logic [31:0] offset;

  // Only offset bits [18:2] reach the 18-bit halfword bus; the rest is dropped on purpose.
  assign offset    = address - BASE;
  assign req       = wr_en | rd_en;
  assign in_beat   = (state_q == S_LOW) || (state_q == S_HIGH);
  assign last_beat = (cnt_q == WS);

  assign ready = (state_q == S_DONE) || ((state_q == S_IDLE) && !req);

  always_comb begin
    SRAM_ADDR = '0;
    case (state_q)
      S_LOW:   SRAM_ADDR = {word_q, 1'b0};
      S_HIGH:  SRAM_ADDR = {word_q, 1'b1};
      default: SRAM_ADDR = '0;
    endcase
  end

  assign dq_drive  = wr_q && in_beat;
  assign SRAM_WE_N = ~dq_drive;
  assign dq_out    = (state_q == S_HIGH) ? wdata_q[31:16] : wdata_q[15:0];
  assign SRAM_DQ   = dq_drive ? dq_out : 16'hzzzz;
  assign read_data = rdata_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    word_d  = word_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = S_LOW;
          cnt_d   = '0;
          wr_d    = wr_en;
          word_d  = offset[18:2];
          wdata_d = write_data;
        end
      end
      S_LOW: begin
        if (last_beat) begin
          state_d = S_HIGH;
          cnt_d   = '0;
          if (!wr_q) rdata_d[15:0] = SRAM_DQ;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_HIGH: begin
        if (last_beat) begin
          state_d = S_DONE;
          cnt_d   = '0;
          if (!wr_q) rdata_d[31:16] = SRAM_DQ;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      // A request seen here belongs to the instruction leaving MEM; the next one is re-presented in IDLE.
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
    end
  end

  // Latched request fields only matter while a beat is active, so they carry no reset.
  always_ff @(posedge clk) begin
    word_q  <= word_d;
    wdata_q <= wdata_d;
  end

endmodule
